reqack_mem_port: RTL and testbench
==================================

Name: reqack_mem_port

Overview:
Memory-domain responder for the toggle req/ack bus bridge. It synchronizes the incoming `req` toggle and detects a new request. It then performs one word access on a synchronous valid/ready memory port, captures read data, and flips `ack`. It sits directly downstream of the bus-side req/ack bridge, in the RAM clock domain.

Parameters:
- ADDRWIDTH, 20: byte-address width of `req_addr`; bits [1:0] are ignored (word access).
- DATAWIDTH, 32: data width, 1..32.
- TIMEOUT, 255: cycles allowed for mem acceptance plus read return; used only with REQACK_TIMEOUT_EN; 8-bit counter.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on timeout; truncated to DATAWIDTH.

Ports:
- clk, in, 1: memory-domain clock.
- reset, in, 1: asynchronous, active-high reset.
- req_addr, in, ADDRWIDTH: request address; stable whenever `req` has flipped.
- wr_data, in, DATAWIDTH: write data; stable with `req_addr`.
- rd_wr_l, in, 1: 1 = read, 0 = write.
- req, in, 1: toggles once per request; asynchronous to clk.
- rd_data, out, DATAWIDTH: read return; stable from the cycle before `ack` flips until the next capture.
- ack, out, 1: toggles once per completed request.
- mem_valid, out, 1: access request to memory.
- mem_addr, out, ADDRWIDTH-2: word address, equal to req_addr[ADDRWIDTH-1:2].
- mem_we, out, 1: 1 = write.
- mem_wdata, out, DATAWIDTH: write data to memory.
- mem_ready, in, 1: memory accepts the access when mem_valid && mem_ready.
- mem_rvalid, in, 1: read data valid, at least 1 cycle after acceptance.
- mem_rdata, in, DATAWIDTH: read data.
- timeout_err, out, 1: sticky timeout flag; port exists only with REQACK_TIMEOUT_EN.

Behaviour:
- Reset (async, active-high): every output 0; state IDLE; sync flops 0; req_old 0.
- The requester must be reset concurrently so that req and ack parity start equal at 0.
- Synchronization: req passes through a 2-flop synchronizer to give req_s.
- A request is pending when req_s != req_old.
- req_addr, wr_data and rd_wr_l are sampled without synchronizers; they are guaranteed stable by the time req_s changes.
- State machine, all outputs registered:
  - IDLE: when a request is pending, latch mem_addr, mem_wdata and mem_we = !rd_wr_l; set req_old <= req_s; set mem_valid <= 1; go to ISSUE.
  - ISSUE: hold mem_valid and all fields until mem_valid && mem_ready. On acceptance, drop mem_valid the next cycle. A write goes to ACK; a read goes to WAIT_RD. mem_rvalid is ignored in ISSUE.
  - WAIT_RD: on mem_rvalid, set rd_data <= mem_rdata and go to ACK.
  - ACK: set ack <= ~ack and go to IDLE.
- Latency, with the request detected at edge N (IDLE → ISSUE):
  - mem_valid is high in cycle N+1.
  - Write with mem_ready already high: ack toggles at edge N+2.
  - Read with mem_rvalid at edge R: rd_data updates at R and ack toggles at R+1.
- mem_rvalid outside WAIT_RD is ignored. A read response arriving after a timeout is a memory fault and is not tracked.
- rd_data is unchanged by writes and holds its last read value.
- Protocol violation: if req toggles twice while busy, parity hides the second request and it is lost. This is not detected.
- Back-to-back requests: a new pending request is accepted in IDLE on the cycle after ACK, which gives a 1 idle cycle minimum between requests.

Optional Feature:
- Macro: REQACK_TIMEOUT_EN.
- With the macro:
  - An 8-bit counter clears on entering ISSUE and increments in ISSUE and WAIT_RD.
  - When the count reaches TIMEOUT: drop mem_valid; for a read, set rd_data <= ERR_DATA; set timeout_err <= 1 (sticky until reset); go to ACK.
  - A normal completion in the same cycle as the timeout takes priority.
- Without the macro: no counter, no timeout_err port; the block waits indefinitely.

Decomposition:
- Shared package holds:
  - State encoding: IDLE = 2'd0, ISSUE = 2'd1, WAIT_RD = 2'd2, ACK = 2'd3.
  - Default ERR_DATA constant.
- Sub-module `sync_h`: a 2-flop synchronizer with async active-high reset, also reusable elsewhere.

Test Plan:
- Read: after reset, set req_addr = 0x00124, rd_wr_l = 1, toggle req; mem_ready = 1; mem_rvalid 3 cycles after acceptance with 0x1234_5678 → mem_addr = 0x00049, mem_we = 0; rd_data = 0x1234_5678 one cycle before ack flips to 1.
- Write with backpressure: wr_data = 0xA5A5_0F0F, rd_wr_l = 0; mem_ready low for 4 cycles → mem_valid and fields held constant for all 4 cycles; ack flips exactly 1 cycle after acceptance; rd_data unchanged.
- Back-to-back: 3 alternating requests, each issued when the prior ack flip is observed → exactly 3 mem accesses in order; ack toggles 3 times, ending at 1.
- Reset in WAIT_RD: assert reset → ack = 0, mem_valid = 0, state IDLE; a subsequent request after both sides are reset completes normally.
- Timeout (REQACK_TIMEOUT_EN, TIMEOUT = 10): read request with mem_ready stuck low → ack flips after 10 cycles in ISSUE; rd_data = 0xDEAD_BEEF; timeout_err = 1 and stays 1.
- Stray mem_rvalid pulse in IDLE → rd_data and ack unchanged.

Source files
------------

// File: rtl/reqack_mem_port_pkg.sv
// Shared definitions for the memory-domain req/ack responder: FSM encoding and
// the default data word returned when a read times out.
package reqack_mem_port_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_WAIT_RD = 2'd2;
  localparam state_t ST_ACK     = 2'd3;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

endpackage

// File: rtl/reqack_mem_port_sync_h.sv
// Two-flop synchronizer with asynchronous active-high reset; generic enough to be
// reused for any level or toggle signal crossing into clk_i.
module sync_h #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reqack_mem_port.sv
// Memory-side responder of the toggle req/ack bridge: one word access per req flip.
// Optional macro REQACK_TIMEOUT_EN adds a bounded wait and a sticky timeout_err port.
module reqack_mem_port
  import reqack_mem_port_pkg::*;
#(
  parameter int          ADDRWIDTH = 20,
  parameter int          DATAWIDTH = 32,
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDRWIDTH-1:0] req_addr,
  input  logic [DATAWIDTH-1:0] wr_data,
  input  logic                 rd_wr_l,
  input  logic                 req,
  output logic [DATAWIDTH-1:0] rd_data,
  output logic                 ack,
  output logic                 mem_valid,
  output logic [ADDRWIDTH-3:0] mem_addr,
  output logic                 mem_we,
  output logic [DATAWIDTH-1:0] mem_wdata,
  input  logic                 mem_ready,
  input  logic                 mem_rvalid,
`ifdef REQACK_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  input  logic [DATAWIDTH-1:0] mem_rdata
);

  logic                 req_s;
  state_t               state_q, state_d;
  logic                 req_old_q, req_old_d;
  logic                 ack_q, ack_d;
  logic                 mem_valid_q, mem_valid_d;
  logic [ADDRWIDTH-3:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [DATAWIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATAWIDTH-1:0] rd_data_q, rd_data_d;
  logic                 accept;

  // Byte-offset bits never reach the word-addressed memory.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[1:0];

`ifdef REQACK_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT);
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       terr_q, terr_d;
  logic       tmo;
  assign cnt_inc = cnt_q + 8'd1;
  assign tmo     = (cnt_inc == TIMEOUT_LIMIT);
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, ERR_DATA};
`endif

  sync_h #(.WIDTH(1)) u_req_sync (
    .clk_i (clk),
    .rst_i (reset),
    .d_i   (req),
    .q_o   (req_s)
  );

  assign accept = mem_valid_q && mem_ready;

  always_comb begin
    state_d     = state_q;
    req_old_d   = req_old_q;
    ack_d       = ack_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    rd_data_d   = rd_data_q;
`ifdef REQACK_TIMEOUT_EN
    cnt_d  = cnt_q;
    terr_d = terr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_s != req_old_q) begin
          mem_addr_d  = req_addr[ADDRWIDTH-1:2];
          mem_wdata_d = wr_data;
          mem_we_d    = !rd_wr_l;
          req_old_d   = req_s;
          mem_valid_d = 1'b1;
          state_d     = ST_ISSUE;
`ifdef REQACK_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      ST_ISSUE: begin
`ifdef REQACK_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        // A write is complete on acceptance; a read is not, so the timeout outranks it.
        if (accept && mem_we_q) begin
          mem_valid_d = 1'b0;
          state_d     = ST_ACK;
        end
`ifdef REQACK_TIMEOUT_EN
        else if (tmo) begin
          mem_valid_d = 1'b0;
          if (!mem_we_q) begin
            rd_data_d = ERR_DATA[DATAWIDTH-1:0];
          end
          terr_d  = 1'b1;
          state_d = ST_ACK;
        end
`endif
        else if (accept) begin
          mem_valid_d = 1'b0;
          state_d     = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
`ifdef REQACK_TIMEOUT_EN
        cnt_d = cnt_inc;
`endif
        if (mem_rvalid) begin
          rd_data_d = mem_rdata;
          state_d   = ST_ACK;
        end
`ifdef REQACK_TIMEOUT_EN
        else if (tmo) begin
          rd_data_d = ERR_DATA[DATAWIDTH-1:0];
          terr_d    = 1'b1;
          state_d   = ST_ACK;
        end
`endif
      end
      default: begin
        ack_d   = ~ack_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_old_q   <= 1'b0;
      ack_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      rd_data_q   <= '0;
`ifdef REQACK_TIMEOUT_EN
      cnt_q  <= '0;
      terr_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      req_old_q   <= req_old_d;
      ack_q       <= ack_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rd_data_q   <= rd_data_d;
`ifdef REQACK_TIMEOUT_EN
      cnt_q  <= cnt_d;
      terr_q <= terr_d;
`endif
    end
  end

  assign rd_data   = rd_data_q;
  assign ack       = ack_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
`ifdef REQACK_TIMEOUT_EN
  assign timeout_err = terr_q;
`endif

endmodule

// File: tb/tb_reqack_mem_port.sv
// Bench for reqack_mem_port: acts as requester and as a randomized memory, with a
// transaction-level model checked every cycle. Define REQACK_TIMEOUT_EN to cover the timeout.
module tb_reqack_mem_port;

  localparam int AW  = 20;
  localparam int DW  = 32;
  localparam int TMO = 10;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } txn_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] wr_data;
  logic          rd_wr_l;
  logic          req;
  logic [DW-1:0] rd_data;
  logic          ack;
  logic          mem_valid;
  logic [AW-3:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready  = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata  = '0;
`ifdef REQACK_TIMEOUT_EN
  logic          timeout_err;
`endif

  reqack_mem_port #(
    .ADDRWIDTH (AW),
    .DATAWIDTH (DW),
    .TIMEOUT   (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_addr   (req_addr),
    .wr_data    (wr_data),
    .rd_wr_l    (rd_wr_l),
    .req        (req),
    .rd_data    (rd_data),
    .ack        (ack),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
`ifdef REQACK_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model state (written by the compare process unless noted).
  txn_t          req_q[$];
  logic          exp_ack, exp_rd_valid_dummy;
  logic [DW-1:0] exp_rd;
  logic          exp_terr;
  logic          ack_pending;
  logic          rd_out;
  int            rv_left;
  logic          busy, busy_we;
  int            bcnt;
  int            n_acc = 0;
  int            stall_cnt = 0;
  int            valid_hi_cnt = 0;
  logic [AW-3:0] last_addr;
  logic          last_we;
  // Previous-negedge samples: what the DUT saw at the posedge just passed.
  logic          p_valid, p_ready, p_rv_real, p_we;
  logic [DW-1:0] p_rdata;
  logic [AW-3:0] p_addr;
  // Memory behaviour knobs (written by stimulus).
  int            ready_mode  = 1;
  int            low_left    = 0;
  int            fixed_delay = 0;
  logic          fixed_rdata_en = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  logic          stray_req = 1'b0;
  logic          ack_par = 1'b0;

  initial begin : compare
    logic acc_now, tmo_now, done;
    txn_t cur, hd;
    forever begin
      @(negedge clk);
      if (reset) begin
        req_q.delete();
        exp_ack = 1'b0; exp_rd = '0; exp_terr = 1'b0; ack_pending = 1'b0;
        rd_out = 1'b0; rv_left = 0; busy = 1'b0; busy_we = 1'b0; bcnt = 0;
        p_valid = 1'b0; p_ready = 1'b0; p_rv_real = 1'b0; p_we = 1'b0;
        p_rdata = '0; p_addr = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0;
        chk("reset_ack", 32'(ack), 32'd0);
        chk("reset_valid", 32'(mem_valid), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
`ifdef REQACK_TIMEOUT_EN
        chk("reset_timeout_err", 32'(timeout_err), 32'd0);
`endif
      end else begin
        acc_now = 1'b0; tmo_now = 1'b0; done = 1'b0;
        // ack flips one edge after the completing edge.
        if (ack_pending) begin
          exp_ack = ~exp_ack;
          ack_pending = 1'b0;
        end
        if (p_valid && !p_ready) stall_cnt++;
        if (p_rv_real) begin
          exp_rd = p_rdata; ack_pending = 1'b1; rd_out = 1'b0; busy = 1'b0; done = 1'b1;
        end
        if (p_valid && p_ready) begin
          acc_now = 1'b1;
          chk("accept_has_req", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            cur = req_q.pop_front();
            n_acc++;
            last_addr = p_addr;
            last_we   = p_we;
            if (cur.we) begin
              ack_pending = 1'b1; busy = 1'b0; done = 1'b1;
            end else begin
              rd_out  = 1'b1;
              rv_left = (fixed_delay != 0) ? fixed_delay : int'($urandom_range(1, 4));
            end
          end
        end
`ifdef REQACK_TIMEOUT_EN
        if (busy && !done) begin
          bcnt++;
          if (bcnt == TMO) begin
            tmo_now = 1'b1;
            if (!rd_out && req_q.size() != 0) void'(req_q.pop_front());
            rd_out = 1'b0; rv_left = 0;
            if (!busy_we) exp_rd = 32'hDEAD_BEEF;
            exp_terr = 1'b1; ack_pending = 1'b1; busy = 1'b0;
          end
        end
`endif
        if (!busy && mem_valid && req_q.size() != 0) begin
          busy = 1'b1; bcnt = 0; busy_we = req_q[0].we;
        end
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("rd_data", rd_data, exp_rd);
        if (acc_now || tmo_now) chk("valid_drop", 32'(mem_valid), 32'd0);
        if (mem_valid) begin
          valid_hi_cnt++;
          chk("valid_has_req", 32'(req_q.size() != 0), 32'd1);
          if (req_q.size() != 0) begin
            hd = req_q[0];
            chk("mem_addr", 32'(mem_addr), 32'(hd.addr[AW-1:2]));
            chk("mem_we", 32'(mem_we), 32'(hd.we));
            chk("mem_wdata", mem_wdata, hd.wdata);
          end
        end
`ifdef REQACK_TIMEOUT_EN
        chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
`endif
        // Drive the memory side for the next edge.
        mem_rdata  = $urandom();
        mem_rvalid = 1'b0;
        p_rv_real  = 1'b0;
        if (rd_out) begin
          if (rv_left > 0) rv_left--;
          if (rv_left == 0) begin
            mem_rvalid = 1'b1;
            p_rv_real  = 1'b1;
            if (fixed_rdata_en) mem_rdata = fixed_rdata;
          end
        end else if (stray_req) begin
          mem_rvalid = 1'b1;
          stray_req  = 1'b0;
        end
        case (ready_mode)
          0: mem_ready = ($urandom_range(0, 3) != 0);
          2: begin
            if (mem_valid && low_left > 0) begin
              mem_ready = 1'b0;
              low_left--;
            end else begin
              mem_ready = 1'b1;
            end
          end
          3: mem_ready = 1'b0;
          default: mem_ready = 1'b1;
        endcase
        p_valid = mem_valid; p_ready = mem_ready; p_rdata = mem_rdata;
        p_addr  = mem_addr;  p_we    = mem_we;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input logic rd, input logic [DW-1:0] wd,
                       input logic wait_it);
    txn_t t;
    int   n;
    logic target;
    target   = ~ack_par;
    req_addr = a; rd_wr_l = rd; wr_data = wd;
    t.addr = a; t.we = ~rd; t.wdata = wd;
    req_q.push_back(t);
    req = ~req;
    if (wait_it) begin
      n = 0;
      while (ack !== target && n < 200) begin
        @(posedge clk); #3;
        n++;
      end
      chk("ack_arrives", 32'(ack), 32'(target));
      ack_par = target;
      $display("txn %s addr=%h wdata=%h rd_data=%h ack=%b cycles=%0d",
               rd ? "RD" : "WR", a, wd, rd_data, ack, n);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int acc0, tries;
    reset = 1'b1; req = 1'b0; req_addr = '0; wr_data = '0; rd_wr_l = 1'b1;
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk("init_ack", 32'(ack), 32'd0);
    chk("init_valid", 32'(mem_valid), 32'd0);

    // Read with fixed 3-cycle return
    ready_mode = 1; fixed_delay = 3; fixed_rdata_en = 1'b1; fixed_rdata = 32'h1234_5678;
    issue(20'h00124, 1'b1, 32'h0, 1'b1);
    chk("read_rd_data", rd_data, 32'h1234_5678);
    chk("read_mem_addr", 32'(last_addr), 32'h49);
    chk("read_mem_we", 32'(last_we), 32'd0);
    chk("read_ack", 32'(ack), 32'd1);

    // Write with 4 cycles of backpressure
    fixed_delay = 0; fixed_rdata_en = 1'b0;
    ready_mode = 2; low_left = 4; stall_cnt = 0;
    issue(20'h00200, 1'b0, 32'hA5A5_0F0F, 1'b1);
    chk("write_stalls", 32'(stall_cnt), 32'd4);
    chk("write_rd_data_kept", rd_data, 32'h1234_5678);
    chk("write_mem_addr", 32'(last_addr), 32'h80);
    chk("write_mem_we", 32'(last_we), 32'd1);

    // Back-to-back alternating requests
    ready_mode = 1; acc0 = n_acc;
    issue(20'h00010, 1'b1, 32'h0000_0001, 1'b1);
    issue(20'h00014, 1'b0, 32'h0000_0002, 1'b1);
    issue(20'h00018, 1'b1, 32'h0000_0003, 1'b1);
    chk("b2b_accesses", 32'(n_acc - acc0), 32'd3);
    chk("b2b_ack", 32'(ack), 32'd1);

    // Randomized traffic with occasional stray read returns while idle
    ready_mode = 0;
    for (int i = 0; i < 40; i++) begin
      issue(20'($urandom()), 1'($urandom()), $urandom(), 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        stray_req = 1'b1;
        cycles(2);
      end
    end

    // Stray mem_rvalid in IDLE must not disturb rd_data or ack
    ready_mode = 1; fixed_delay = 1; fixed_rdata_en = 1'b1; fixed_rdata = 32'hCAFE_F00D;
    issue(20'h00040, 1'b1, 32'h0, 1'b1);
    stray_req = 1'b1;
    cycles(4);
    chk("stray_rd_data", rd_data, 32'hCAFE_F00D);
    chk("stray_ack", 32'(ack), 32'(ack_par));

    // Reset while waiting for read data
    fixed_delay = 40;
    issue(20'h00080, 1'b1, 32'h0, 1'b0);
    tries = 0;
    while (!rd_out && tries < 20) begin
      cycles(1);
      tries++;
    end
    chk("reach_wait_rd", 32'(rd_out), 32'd1);
    cycles(2);
    reset = 1'b1; req = 1'b0; ack_par = 1'b0;
    cycles(2);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    reset = 1'b0;
    cycles(1);
    fixed_delay = 2; fixed_rdata = 32'h0BAD_F00D;
    issue(20'h000C0, 1'b1, 32'h0, 1'b1);
    chk("post_rst_rd_data", rd_data, 32'h0BAD_F00D);
    chk("post_rst_ack", 32'(ack), 32'd1);
    fixed_delay = 0; fixed_rdata_en = 1'b0;

`ifdef REQACK_TIMEOUT_EN
    // Read with mem_ready stuck low times out after TMO cycles in ISSUE
    ready_mode = 3; valid_hi_cnt = 0;
    issue(20'h00300, 1'b1, 32'h0, 1'b1);
    chk("tmo_rd_data", rd_data, 32'hDEAD_BEEF);
    chk("tmo_flag", 32'(timeout_err), 32'd1);
    chk("tmo_valid_cycles", 32'(valid_hi_cnt), 32'(TMO));
    ready_mode = 1;
    issue(20'h00304, 1'b0, 32'h5555_AAAA, 1'b1);
    chk("tmo_flag_sticky", 32'(timeout_err), 32'd1);
`endif

    cycles(3);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
